// File: rtl/core_types_pkg.sv
// Shared core types: branch-history-table FSM states, the EXE-slot record
// and the saturating-counter step used for table training.
package core_types_pkg;

   localparam int BHT_IDX_W_MAX = 16;
   localparam int BHT_CTR_W_MAX = 8;

   typedef enum logic [0:0] {
      BHT_INIT = 1'b0,
      BHT_RUN  = 1'b1
   } bht_state_t;

   typedef struct packed {
      logic                     valid;
      logic [BHT_IDX_W_MAX-1:0] idx;
      logic                     pred;
   } bht_exe_t;

   // Counter is zero-extended into the widest supported width; ctr_max is the top code.
   function automatic logic [BHT_CTR_W_MAX-1:0] sat_update(
      input logic [BHT_CTR_W_MAX-1:0] ctr,
      input logic                     taken,
      input logic [BHT_CTR_W_MAX-1:0] ctr_max
   );
      logic [BHT_CTR_W_MAX-1:0] nxt;
      if (taken) begin
         if (ctr == ctr_max) nxt = ctr;
         else                nxt = ctr + BHT_CTR_W_MAX'(1);
      end else begin
         if (ctr == '0) nxt = ctr;
         else           nxt = ctr - BHT_CTR_W_MAX'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predictor_bht_perf_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module bht_perf_counter
   import core_types_pkg::*;
#(
   parameter int PERF_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic                  inc,
   input  logic                  clr,
   output logic [PERF_WIDTH-1:0] count
);

   // Count holds at all-ones rather than wrapping.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + PERF_WIDTH'(1);
      end
   end

endmodule

// File: rtl/branch_predictor_bht.sv
// Per-PC branch history table of saturating counters with a DEC->EXE
// prediction slot, resolve-time training and misprediction statistics.
module branch_predictor_bht
   import core_types_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int CTR_BITS   = 2,
   parameter int INIT_VALUE = 1,
   parameter int PERF_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic                  lookupValid,
   input  logic [31:0]           lookupPC,
   output logic                  lookupTaken,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  resolveValid,
   input  logic                  resolveTaken,
   output logic                  predictedEXE,
   output logic                  mispredict,
   output logic                  ready,
   input  logic                  clearStats,
   output logic [PERF_WIDTH-1:0] branchCount,
   output logic [PERF_WIDTH-1:0] mispredCount
);

   localparam int DEPTH = 1 << INDEX_BITS;
   localparam logic [CTR_BITS-1:0]      CTR_INIT = CTR_BITS'(INIT_VALUE);
   localparam logic [BHT_CTR_W_MAX-1:0] CTR_MAX  = BHT_CTR_W_MAX'((1 << CTR_BITS) - 1);

   logic [CTR_BITS-1:0]      bht_r [DEPTH];
   bht_state_t               state_r, state_nxt_s;
   logic [INDEX_BITS-1:0]    init_ptr_r, init_ptr_nxt_s;
   bht_exe_t                 exe_r, exe_nxt_s;
   logic                     ready_r;
   logic [INDEX_BITS-1:0]    idx_s, exe_idx_s;
   logic                     commit_s;
   logic [BHT_CTR_W_MAX-1:0] upd_wide_s;
   logic [CTR_BITS-1:0]      upd_ctr_s, look_ctr_s;
   logic                     unused_s;

   assign idx_s     = lookupPC[INDEX_BITS+1:2];
   assign exe_idx_s = exe_r.idx[INDEX_BITS-1:0];
   assign commit_s  = ready_r && exe_r.valid && resolveValid && !stall;
   assign unused_s  = ^{lookupPC, exe_r.idx, upd_wide_s};

   // Prediction forwards the counter being written this cycle when indices collide.
   always_comb begin
      upd_wide_s = sat_update(BHT_CTR_W_MAX'(bht_r[exe_idx_s]), resolveTaken, CTR_MAX);
      upd_ctr_s  = upd_wide_s[CTR_BITS-1:0];
      if (commit_s && (exe_idx_s == idx_s)) look_ctr_s = upd_ctr_s;
      else                                  look_ctr_s = bht_r[idx_s];
      lookupTaken = ready_r && look_ctr_s[CTR_BITS-1];
      mispredict  = commit_s && (exe_r.pred != resolveTaken);
   end

   // Init sweep walks every entry once, then the table stays in service until reset.
   always_comb begin
      state_nxt_s    = state_r;
      init_ptr_nxt_s = init_ptr_r;
      case (state_r)
         BHT_INIT: begin
            init_ptr_nxt_s = init_ptr_r + INDEX_BITS'(1);
            if (init_ptr_r == INDEX_BITS'(DEPTH - 1)) state_nxt_s = BHT_RUN;
            else                                      state_nxt_s = BHT_INIT;
         end
         BHT_RUN:  state_nxt_s = BHT_RUN;
         default:  state_nxt_s = BHT_INIT;
      endcase
   end

   // EXE slot freezes on stall; flush and an unready table both squash the entry.
   always_comb begin
      exe_nxt_s = exe_r;
      if (!stall) begin
         exe_nxt_s.valid = lookupValid && !flush && ready_r;
         exe_nxt_s.idx   = BHT_IDX_W_MAX'(idx_s);
         exe_nxt_s.pred  = lookupTaken;
      end else begin
         exe_nxt_s = exe_r;
      end
   end

   // Control and EXE-slot registers.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_r    <= BHT_INIT;
         init_ptr_r <= '0;
         ready_r    <= 1'b0;
         exe_r      <= '0;
      end else begin
         state_r    <= state_nxt_s;
         init_ptr_r <= init_ptr_nxt_s;
         ready_r    <= (state_nxt_s == BHT_RUN);
         exe_r      <= exe_nxt_s;
      end
   end

   // Table storage carries no reset; the sweep defines its contents.
   always_ff @(posedge Clock) begin
      if (state_r == BHT_INIT) begin
         bht_r[init_ptr_r] <= CTR_INIT;
      end else if (commit_s) begin
         bht_r[exe_idx_s] <= upd_ctr_s;
      end
   end

   assign ready        = ready_r;
   assign predictedEXE = exe_r.pred;

   bht_perf_counter #(.PERF_WIDTH(PERF_WIDTH)) u_branch_cnt (
      .Clock  (Clock),
      .nReset (nReset),
      .inc    (commit_s),
      .clr    (clearStats),
      .count  (branchCount)
   );

   bht_perf_counter #(.PERF_WIDTH(PERF_WIDTH)) u_mispred_cnt (
      .Clock  (Clock),
      .nReset (nReset),
      .inc    (mispredict),
      .clr    (clearStats),
      .count  (mispredCount)
   );

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: directed scenarios and random traffic
// checked against a table-of-integers reference model.
module tb_branch_predictor_bht;

   logic        Clock, nReset;
   logic        lookupValid, stall, flush, resolveValid, resolveTaken, clearStats;
   logic [31:0] lookupPC;
   logic        lookupTaken, predictedEXE, mispredict, ready;
   logic [31:0] branchCount, mispredCount;
   logic        lookupTaken4, predictedEXE4, mispredict4, ready4;
   logic [3:0]  branchCount4, mispredCount4;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int     m_tbl [64];
   bit     m_ready, m_ev, m_epred;
   int     m_init, m_eidx;
   longint m_bc, m_mc, m_bc4, m_mc4;
   bit     e_lt, e_mp, e_commit;
   int     e_upd;

   branch_predictor_bht dut (
      .Clock(Clock), .nReset(nReset), .lookupValid(lookupValid), .lookupPC(lookupPC),
      .lookupTaken(lookupTaken), .stall(stall), .flush(flush), .resolveValid(resolveValid),
      .resolveTaken(resolveTaken), .predictedEXE(predictedEXE), .mispredict(mispredict),
      .ready(ready), .clearStats(clearStats), .branchCount(branchCount), .mispredCount(mispredCount)
   );

   branch_predictor_bht #(.PERF_WIDTH(4)) dut4 (
      .Clock(Clock), .nReset(nReset), .lookupValid(lookupValid), .lookupPC(lookupPC),
      .lookupTaken(lookupTaken4), .stall(stall), .flush(flush), .resolveValid(resolveValid),
      .resolveTaken(resolveTaken), .predictedEXE(predictedEXE4), .mispredict(mispredict4),
      .ready(ready4), .clearStats(clearStats), .branchCount(branchCount4), .mispredCount(mispredCount4)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic model_reset();
      m_ready = 1'b0; m_init = 0; m_ev = 1'b0; m_eidx = 0; m_epred = 1'b0;
      m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
      foreach (m_tbl[i]) m_tbl[i] = -1;
   endtask

   task automatic model_eval();
      int idx, c;
      idx      = int'((lookupPC / 4) % 64);
      e_commit = m_ready && m_ev && resolveValid && !stall;
      e_mp     = e_commit && (m_epred != resolveTaken);
      if (resolveTaken) e_upd = (m_tbl[m_eidx] >= 3) ? 3 : m_tbl[m_eidx] + 1;
      else              e_upd = (m_tbl[m_eidx] <= 0) ? 0 : m_tbl[m_eidx] - 1;
      c    = (e_commit && m_eidx == idx) ? e_upd : m_tbl[idx];
      e_lt = m_ready && (c >= 2);
   endtask

   task automatic model_step();
      bit was_ready;
      int idx;
      was_ready = m_ready;
      idx       = int'((lookupPC / 4) % 64);
      if (clearStats) begin
         m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
      end else if (e_commit) begin
         m_bc  = (m_bc  == 64'hFFFF_FFFF) ? m_bc  : m_bc + 1;
         m_bc4 = (m_bc4 == 15) ? m_bc4 : m_bc4 + 1;
         if (e_mp) begin
            m_mc  = (m_mc  == 64'hFFFF_FFFF) ? m_mc  : m_mc + 1;
            m_mc4 = (m_mc4 == 15) ? m_mc4 : m_mc4 + 1;
         end
      end
      if (e_commit) m_tbl[m_eidx] = e_upd;
      if (!stall) begin
         m_ev = lookupValid && !flush && was_ready;
         m_eidx = idx;
         m_epred = e_lt;
      end
      if (!m_ready) begin
         m_init++;
         if (m_init == 64) begin
            m_ready = 1'b1;
            foreach (m_tbl[i]) m_tbl[i] = 1;
         end
      end
   endtask

   task automatic apply(input logic a_lv, input logic [31:0] a_pc, input logic a_st,
                        input logic a_fl, input logic a_rv, input logic a_rt, input logic a_clr);
      lookupValid = a_lv; lookupPC = a_pc; stall = a_st; flush = a_fl;
      resolveValid = a_rv; resolveTaken = a_rt; clearStats = a_clr;
      #1;
      model_eval();
   endtask

   task automatic advance();
      @(posedge Clock);
      model_step();
      @(negedge Clock);
   endtask

   task automatic test_reset(input string tag);
      nReset = 1'b0;
      model_reset();
      apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL %s rst_ready: got %0b want 0", tag, ready); end
      n_vec++; if (predictedEXE !== 1'b0) begin n_err++; $display("FAIL %s rst_pred: got %0b want 0", tag, predictedEXE); end
      n_vec++; if (branchCount !== 32'd0 || mispredCount !== 32'd0) begin
         n_err++; $display("FAIL %s rst_counts: got %0d/%0d want 0/0", tag, branchCount, mispredCount); end
      n_vec++; if (branchCount4 !== 4'd0 || mispredCount4 !== 4'd0) begin
         n_err++; $display("FAIL %s rst_counts4: got %0d/%0d want 0/0", tag, branchCount4, mispredCount4); end
      repeat (3) @(negedge Clock);
      nReset = 1'b1;
      for (int c = 0; c < 64; c++) begin
         apply(1'b1, $urandom, 1'b0, 1'b0, 1'(($urandom % 2)), 1'b1, 1'b0);
         n_vec++; if (ready !== 1'b0 || lookupTaken !== 1'b0 || mispredict !== 1'b0) begin
            n_err++; $display("FAIL %s init_cycle%0d: got rdy=%0b lt=%0b mp=%0b want 0/0/0", tag, c, ready, lookupTaken, mispredict); end
         advance();
      end
      for (int i = 0; i < 64; i++) begin
         apply(1'b0, 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL %s ready_after_init: got %0b want 1", tag, ready); end
         n_vec++; if (dut.bht_r[i] !== 2'd1 || lookupTaken !== 1'b0) begin
            n_err++; $display("FAIL %s init_entry%0d: got ctr=%0d lt=%0b want 1/0", tag, i, dut.bht_r[i], lookupTaken); end
         advance();
      end
   endtask

   task automatic test_training();
      apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); advance();
      for (int r = 0; r < 3; r++) begin
         apply(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         n_vec++; if (lookupTaken !== (r != 0)) begin n_err++; $display("FAIL train_pred%0d: got %0b want %0b", r, lookupTaken, r != 0); end
         advance();
         apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         n_vec++; if (mispredict !== (r == 0)) begin n_err++; $display("FAIL train_mp%0d: got %0b want %0b", r, mispredict, r == 0); end
         advance();
         n_vec++; if (dut.bht_r[1] !== ((r == 0) ? 2'd2 : 2'd3)) begin
            n_err++; $display("FAIL train_entry%0d: got %0d want %0d", r, dut.bht_r[1], (r == 0) ? 2 : 3); end
      end
      n_vec++; if (branchCount !== 32'd3 || mispredCount !== 32'd1) begin
         n_err++; $display("FAIL train_counts: got %0d/%0d want 3/1", branchCount, mispredCount); end
   endtask

   task automatic test_sat_low();
      apply(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (lookupTaken !== 1'b0) begin n_err++; $display("FAIL satlo_pred0: got %0b want 0", lookupTaken); end
      advance();
      apply(1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++; if (lookupTaken !== 1'b0 || mispredict !== 1'b0) begin
         n_err++; $display("FAIL satlo_first: got lt=%0b mp=%0b want 0/0", lookupTaken, mispredict); end
      advance();
      n_vec++; if (dut.bht_r[2] !== 2'd0) begin n_err++; $display("FAIL satlo_entry1: got %0d want 0", dut.bht_r[2]); end
      apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL satlo_mp2: got %0b want 0", mispredict); end
      advance();
      n_vec++; if (dut.bht_r[2] !== 2'd0) begin n_err++; $display("FAIL satlo_entry2: got %0d want 0", dut.bht_r[2]); end
   endtask

   task automatic test_alias_bypass();
      apply(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (lookupTaken !== 1'b1) begin n_err++; $display("FAIL alias_pred: got %0b want 1", lookupTaken); end
      advance();
      apply(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++; if (lookupTaken !== 1'b1 || mispredict !== 1'b1) begin
         n_err++; $display("FAIL bypass_3to2: got lt=%0b mp=%0b want 1/1", lookupTaken, mispredict); end
      advance();
      apply(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++; if (lookupTaken !== 1'b0 || mispredict !== 1'b1) begin
         n_err++; $display("FAIL bypass_2to1: got lt=%0b mp=%0b want 0/1", lookupTaken, mispredict); end
      advance();
      n_vec++; if (dut.bht_r[1] !== 2'd1) begin n_err++; $display("FAIL bypass_entry: got %0d want 1", dut.bht_r[1]); end
      apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); advance();
   endtask

   task automatic test_flush_stall();
      apply(1'b1, 32'h10C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); advance();
      apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL flush_mp: got %0b want 0", mispredict); end
      advance();
      n_vec++; if (dut.bht_r[3] !== 2'd1 || branchCount !== 32'd7) begin
         n_err++; $display("FAIL flush_state: got ctr=%0d bc=%0d want 1/7", dut.bht_r[3], branchCount); end
      apply(1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); advance();
      for (int s = 0; s < 3; s++) begin
         apply(1'b1, 32'h10C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
         n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL stall_mp%0d: got %0b want 0", s, mispredict); end
         advance();
         n_vec++; if (dut.bht_r[3] !== 2'd1) begin n_err++; $display("FAIL stall_entry%0d: got %0d want 1", s, dut.bht_r[3]); end
      end
      apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL unstall_mp: got %0b want 1", mispredict); end
      advance();
      n_vec++; if (dut.bht_r[3] !== 2'd2 || branchCount !== 32'd8 || mispredCount !== 32'd4) begin
         n_err++; $display("FAIL unstall_state: got ctr=%0d bc=%0d mc=%0d want 2/8/4", dut.bht_r[3], branchCount, mispredCount); end
   endtask

   task automatic test_perf_sat();
      apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); advance();
      for (int c = 0; c < 200 && m_mc < 20; c++) begin
         apply(1'b1, 32'h110, 1'b0, 1'b0, 1'b1, !m_epred, 1'b0);
         advance();
      end
      n_vec++; if (mispredCount4 !== 4'd15 || branchCount4 !== 4'd15) begin
         n_err++; $display("FAIL perf4_sat: got mc=%0d bc=%0d want 15/15", mispredCount4, branchCount4); end
      n_vec++; if (mispredCount !== 32'd20 || branchCount !== 32'd20) begin
         n_err++; $display("FAIL perf32_count: got mc=%0d bc=%0d want 20/20", mispredCount, branchCount); end
      apply(1'b1, 32'h110, 1'b0, 1'b0, 1'b1, !m_epred, 1'b1);
      n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL clr_commit_mp: got %0b want 1", mispredict); end
      advance();
      n_vec++; if (branchCount !== 32'd0 || mispredCount !== 32'd0 || branchCount4 !== 4'd0 || mispredCount4 !== 4'd0) begin
         n_err++; $display("FAIL clr_wins: got %0d/%0d/%0d/%0d want 0/0/0/0", branchCount, mispredCount, branchCount4, mispredCount4); end
   endtask

   task automatic test_random(input int cycles);
      logic [31:0] pc;
      for (int c = 0; c < cycles; c++) begin
         pc = $urandom;
         if ($urandom_range(0, 3) != 0) pc = (pc & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
         apply(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
         n_vec++; if (lookupTaken !== e_lt || lookupTaken4 !== e_lt) begin
            n_err++; $display("FAIL rnd_lt c%0d: got %0b/%0b want %0b", c, lookupTaken, lookupTaken4, e_lt); end
         n_vec++; if (mispredict !== e_mp || predictedEXE !== m_epred || ready !== m_ready) begin
            n_err++; $display("FAIL rnd_ctl c%0d: got mp=%0b pred=%0b rdy=%0b want %0b/%0b/%0b", c,
                              mispredict, predictedEXE, ready, e_mp, m_epred, m_ready); end
         n_vec++; if (branchCount !== 32'(m_bc) || mispredCount !== 32'(m_mc) ||
                      branchCount4 !== 4'(m_bc4) || mispredCount4 !== 4'(m_mc4)) begin
            n_err++; $display("FAIL rnd_cnt c%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", c, branchCount,
                              mispredCount, branchCount4, mispredCount4, m_bc, m_mc, m_bc4, m_mc4); end
         advance();
      end
   endtask

   initial begin
      nReset = 1'b0;
      lookupValid = 1'b0; lookupPC = 32'h0; stall = 1'b0; flush = 1'b0;
      resolveValid = 1'b0; resolveTaken = 1'b0; clearStats = 1'b0;
      @(negedge Clock);
      test_reset("por");
      test_training();
      test_alias_bypass();
      test_sat_low();
      test_flush_stall();
      test_perf_sat();
      test_random(1500);
      test_reset("mid");
      test_random(500);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
Parametrised successor to the single-bit global predictor in the branching unit. It provides a table of 2^INDEX_BITS saturating counters indexed by PC bits, so each branch is predicted on its own history. A decode-stage lookup is registered into an execute-stage slot. Resolution in execute updates the table, flags a misprediction and maintains saturating performance counters. A reset-time sweep initialises the table.

Parameters:
INDEX_BITS, 6, table index width; DEPTH = 2^INDEX_BITS entries
CTR_BITS, 2, width of each saturating counter (>=1)
INIT_VALUE, 1, value written to every entry during init (< 2^CTR_BITS)
PERF_WIDTH, 32, width of each performance counter

Ports:
Clock  input  1  clock
nReset  input  1  reset, asynchronous, active-low
lookupValid  input  1  decode stage holds a conditional branch
lookupPC  input  32  PC of the decode-stage instruction
lookupTaken  output  1  prediction for lookupPC (combinational)
stall  input  1  freeze the DEC->EXE slot; no table or perf update this cycle
flush  input  1  squash the instruction entering EXE
resolveValid  input  1  EXE conditional branch resolved this cycle
resolveTaken  input  1  actual outcome (branchConfirmed)
predictedEXE  output  1  prediction carried with the EXE-slot branch
mispredict  output  1  committed resolve with predictedEXE != resolveTaken (combinational)
ready  output  1  table initialised
clearStats  input  1  synchronous clear of the perf counters
branchCount  output  PERF_WIDTH  committed resolves
mispredCount  output  PERF_WIDTH  committed mispredicts

Behaviour:
- Index: idx = lookupPC[INDEX_BITS+1:2]; PC bits [1:0] are ignored. Aliasing is allowed.
- Prediction: lookupTaken = ready && table[idx][CTR_BITS-1].
- FSM states BHT_INIT and BHT_RUN.
  - Reset enters BHT_INIT with initPtr=0.
  - In BHT_INIT, each cycle writes INIT_VALUE to table[initPtr] and increments initPtr.
  - When initPtr==DEPTH-1 is written, the next state is BHT_RUN. Init therefore takes exactly DEPTH cycles.
  - BHT_RUN is held until reset.
  - ready=1 only in BHT_RUN.
- Reset values: state=BHT_INIT, initPtr=0, exeValid=0, exeIdx=0, predictedEXE=0, branchCount=0, mispredCount=0, ready=0. Table contents are don't-care until the sweep completes.
- Reset asserted mid-operation aborts everything and restarts the sweep.
- EXE slot registers (exeValid, exeIdx, predictedEXE):
  - If stall=1, the slot holds.
  - Otherwise it loads exeValid = lookupValid && !flush && ready, exeIdx = idx, predictedEXE = lookupTaken.
  - flush has priority over lookupValid.
- Commit = ready && exeValid && resolveValid && !stall.
  - resolveValid with exeValid=0 is ignored: no update, mispredict=0.
- mispredict = commit && (predictedEXE != resolveTaken).
- Table update on commit:
  - taken: table[exeIdx] increments, saturating at 2^CTR_BITS-1.
  - not taken: table[exeIdx] decrements, saturating at 0.
  - Written at the clock edge.
- Bypass: if a commit targets exeIdx == idx in the same cycle, lookupTaken uses the post-update counter value.
- Perf counters:
  - On commit, branchCount increments and mispredCount increments if mispredict.
  - Both saturate at all-ones.
  - clearStats=1 forces both to 0 next cycle; clearStats wins over a simultaneous increment.
- During BHT_INIT: lookupTaken=0, no commits, perf counters frozen except clearStats.

Decomposition:
- core_types_pkg gains:
  - bht_state_t enum {BHT_INIT, BHT_RUN}
  - bht_exe_t packed struct {valid, idx, pred}
  - function sat_update(ctr, taken) returning the next saturating counter value
- Sub-module bht_perf_counter (PERF_WIDTH parameter; inputs inc and clr; saturating), instantiated twice.
- The table is a plain register array inside branch_predictor_bht.

Test Plan:
1. Default params, release reset -> ready=0 and lookupTaken=0 for 64 cycles; ready=1 on cycle 65; all entries read back as 1 (weakly not-taken).
2. Training on PC 0x104 (idx 1):
   - First lookup predicts 0; resolve taken -> mispredict=1, entry=2.
   - Next lookup predicts 1; resolve taken -> mispredict=0, entry=3.
   - Third taken keeps entry=3.
   - branchCount=3, mispredCount=1.
3. Saturation low: PC 0x108 resolved not-taken twice -> entry 1->0->0, predictions 0, mispredict=0 both times.
4. Aliasing and bypass:
   - Train 0x104 to 3; lookup 0x204 (idx 1) -> predicts 1.
   - Commit not-taken on idx 1 in the same cycle as a lookup of 0x104 -> lookupTaken reflects entry=2 (still 1).
   - From entry=2, a same-cycle not-taken commit -> lookupTaken=0 (entry 1).
5. flush=1 with lookupValid=1, then resolveValid=1 -> no table change, mispredict=0, branchCount unchanged. stall=1 for 3 cycles with resolveValid=1 -> a single update only after stall drops.
6. PERF_WIDTH=4: 20 mispredicting commits -> mispredCount=15. clearStats concurrent with a commit -> both counters 0. Reset pulse mid-run -> ready=0 for 64 cycles again.
